// File: rtl/csa_term_accumulator_if.sv
// Term stream in, redundant (sum, carry) result out, both valid/ready handshakes.
// master drives terms and takes results; slave is the accumulator side.
interface csa_term_accumulator_if #(
  parameter int BIT_LEN   = 19,
  parameter int MAX_TERMS = 16,
  parameter int OUT_LEN   = BIT_LEN + $clog2(MAX_TERMS),
  parameter int CNT_W     = $clog2(MAX_TERMS + 1)
);
  logic               in_valid;
  logic               in_ready;
  logic [BIT_LEN-1:0] in_term;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_LEN-1:0] out_sum;
  logic [OUT_LEN-1:0] out_carry;
  logic [CNT_W-1:0]   out_count;
  logic               out_overflow;

  modport master (
    output in_valid, in_term, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_carry, out_count, out_overflow
  );

  modport slave (
    input  in_valid, in_term, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_carry, out_count, out_overflow
  );
endinterface

// File: rtl/csa_term_accumulator.sv
// Packet accumulator: folds one unsigned term per cycle into a carry-save pair
// with a single 3:2 compressor; the carry-propagate add is left to the consumer.
module csa_term_accumulator #(
  parameter int BIT_LEN   = 19,
  parameter int MAX_TERMS = 16,
  parameter int OUT_LEN   = BIT_LEN + $clog2(MAX_TERMS)
) (
  input logic                    clk,
  input logic                    reset,
  csa_term_accumulator_if.slave  bus
);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  // IDLE waits for the first term, ACCUM folds further terms, DONE presents the result
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]         r_state;
  logic [OUT_LEN-1:0] r_sum;
  logic [OUT_LEN-1:0] r_carry;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_xfer;
  logic               w_cnt_max;
  logic [OUT_LEN-1:0] w_term;
  logic [OUT_LEN-1:0] w_csa_sum;
  logic [OUT_LEN-1:0] w_maj;
  logic [OUT_LEN-1:0] w_csa_carry;

  assign w_in_ready  = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
  assign w_out_valid = (r_state == ST_DONE);
  assign w_xfer      = bus.in_valid && w_in_ready;
  assign w_cnt_max   = (r_count == CNT_W'(MAX_TERMS));

  assign w_term      = OUT_LEN'(bus.in_term);
  assign w_csa_sum   = r_sum ^ r_carry ^ w_term;
  assign w_maj       = (r_sum & r_carry) | (r_sum & w_term) | (r_carry & w_term);
  // Carry moves up one weight; the bit shifted out of the top is dropped (mod 2^OUT_LEN).
  assign w_csa_carry = {w_maj[OUT_LEN-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_sum      <= '0;
      r_carry    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_xfer) begin
            r_sum      <= w_term;
            r_carry    <= '0;
            r_count    <= CNT_W'(1);
            r_overflow <= 1'b0;
            r_state    <= bus.in_last ? ST_DONE : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (w_xfer) begin
            r_sum   <= w_csa_sum;
            r_carry <= w_csa_carry;
            if (w_cnt_max) r_overflow <= 1'b1;
            else           r_count    <= r_count + CNT_W'(1);
            if (bus.in_last) r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = w_out_valid;
  assign bus.out_sum      = w_out_valid ? r_sum   : '0;
  assign bus.out_carry    = w_out_valid ? r_carry : '0;
  assign bus.out_count    = w_out_valid ? r_count : '0;
  assign bus.out_overflow = w_out_valid && r_overflow;
endmodule
